// File: rtl/sad_disparity_core.sv
// sad_disparity_core: streams left/right grey frames and picks the 1xWIN_SIZE row-SAD argmin disparity per pixel.
// Optional macro SAD_COST_OUT_EN adds the disp_cost port carrying the winning window cost.
`timescale 1ns/1ps
`default_nettype none

module sad_disparity_core #(
    parameter int CAMERA_HSIZE   = 100,
    parameter int CAMERA_VSIZE   = 100,
    parameter int PIXEL_WIDTH    = 4,
    parameter int MAX_DISP       = 16,
    parameter int WIN_SIZE       = 5,
    parameter int BUF_ADDR_WIDTH = 32,
    parameter int DISP_WIDTH     = 4,
    localparam int COST_WIDTH    = PIXEL_WIDTH + $clog2(WIN_SIZE) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    output logic [BUF_ADDR_WIDTH-1:0] buf_raddr,
    output logic                      buf_rready,
    input  logic                      buf_rvalid,
    input  logic [PIXEL_WIDTH-1:0]    buf_rdata_l,
    input  logic [PIXEL_WIDTH-1:0]    buf_rdata_r,
    output logic [DISP_WIDTH-1:0]     disp_out,
    output logic                      disp_valid,
    input  logic                      disp_ready,
`ifdef SAD_COST_OUT_EN
    output logic [COST_WIDTH-1:0]     disp_cost,
`endif
    output logic                      sad_done
);

    localparam int NUM_PIX = CAMERA_HSIZE * CAMERA_VSIZE;
    localparam int XW      = $clog2(CAMERA_HSIZE);
    localparam logic [BUF_ADDR_WIDTH-1:0] LAST_ADDR = BUF_ADDR_WIDTH'(NUM_PIX - 1);
    localparam logic [XW-1:0]             LAST_X    = XW'(CAMERA_HSIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [XW-1:0]          x;
    logic                   stall;
    logic                   beat;
    logic                   last_beat;

    // The live right pixel is tap 0, so only MAX_DISP-1 older pixels need storing.
    logic [PIXEL_WIDTH-1:0] r_hist [MAX_DISP-1];
    logic [PIXEL_WIDTH-1:0] ad_line [MAX_DISP][WIN_SIZE];
    logic [COST_WIDTH-1:0]  sad [MAX_DISP];
    logic                   s1_valid;
    logic                   s1_last;
    logic [XW-1:0]          s1_x;
    logic                   disp_last;

    logic [PIXEL_WIDTH-1:0] ad [MAX_DISP];
    logic [COST_WIDTH-1:0]  sad_nxt [MAX_DISP];
    logic [DISP_WIDTH-1:0]  best_d;
    logic [COST_WIDTH-1:0]  best_s;
    logic                   found;

    assign stall      = disp_valid & ~disp_ready;
    assign buf_rready = (state == READ) & ~stall;
    assign beat       = buf_rvalid & buf_rready;
    assign last_beat  = beat & (buf_raddr == LAST_ADDR);
    assign sad_done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = READ;
            READ:    if (last_beat) state_nxt = FLUSH;
            FLUSH:   if (disp_valid && disp_ready && disp_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 1 combinational: absolute differences and sliding window sums; x==0 drops row history.
    always_comb begin
        logic [PIXEL_WIDTH-1:0] rtap;
        logic [PIXEL_WIDTH-1:0] old_ad;
        logic [COST_WIDTH-1:0]  base;
        for (int d = 0; d < MAX_DISP; d++) begin
            ad[d]      = '0;
            sad_nxt[d] = '0;
        end
        for (int d = 0; d < MAX_DISP; d++) begin
            if (d == 0) begin
                rtap = buf_rdata_r;
            end else begin
                rtap = (x == '0) ? '0 : r_hist[(d > 0) ? d - 1 : 0];
            end
            ad[d]      = (buf_rdata_l >= rtap) ? (buf_rdata_l - rtap) : (rtap - buf_rdata_l);
            old_ad     = (x == '0) ? '0 : ad_line[d][WIN_SIZE-1];
            base       = (x == '0) ? '0 : sad[d];
            sad_nxt[d] = base + COST_WIDTH'(ad[d]) - COST_WIDTH'(old_ad);
        end
    end

    // Stage 2 combinational: argmin over candidates whose window lies fully inside the row.
    always_comb begin
        best_d = '0;
        best_s = '0;
        found  = 1'b0;
        for (int d = 0; d < MAX_DISP; d++) begin
            if ((int'(s1_x) >= d + WIN_SIZE - 1) && (!found || (sad[d] < best_s))) begin
                found  = 1'b1;
                best_s = sad[d];
                best_d = DISP_WIDTH'(d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_raddr  <= '0;
            x          <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_x       <= '0;
            disp_out   <= '0;
            disp_valid <= 1'b0;
            disp_last  <= 1'b0;
`ifdef SAD_COST_OUT_EN
            disp_cost  <= '0;
`endif
            for (int i = 0; i < MAX_DISP - 1; i++) r_hist[i] <= '0;
            for (int d = 0; d < MAX_DISP; d++) begin
                sad[d] <= '0;
                for (int k = 0; k < WIN_SIZE; k++) ad_line[d][k] <= '0;
            end
        end else begin
            if (state == IDLE && frame_start) begin
                buf_raddr <= '0;
                x         <= '0;
            end else if (beat) begin
                if (buf_raddr != LAST_ADDR) buf_raddr <= buf_raddr + 1'b1;
                x <= (x == LAST_X) ? '0 : x + 1'b1;
            end

            if (!stall) begin
                s1_valid <= beat;
                s1_last  <= last_beat;
                if (beat) begin
                    s1_x      <= x;
                    r_hist[0] <= buf_rdata_r;
                    for (int i = 1; i < MAX_DISP - 1; i++) begin
                        r_hist[i] <= (x == '0) ? '0 : r_hist[i-1];
                    end
                    for (int d = 0; d < MAX_DISP; d++) begin
                        sad[d]        <= sad_nxt[d];
                        ad_line[d][0] <= ad[d];
                        for (int k = 1; k < WIN_SIZE; k++) begin
                            ad_line[d][k] <= (x == '0) ? '0 : ad_line[d][k-1];
                        end
                    end
                end

                disp_valid <= s1_valid;
                disp_last  <= s1_last;
                if (s1_valid) begin
                    disp_out  <= best_d;
`ifdef SAD_COST_OUT_EN
                    disp_cost <= best_s;
`endif
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sad_disparity_core.sv
// ---------------------------------------------------------------------------
// Module  : tb_sad_disparity_core
// Brief   : frame-level scoreboard bench for sad_disparity_core against a
//           direct SAD model.
// Revision: 1.1
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sad_disparity_core;

    localparam int H  = 100;
    localparam int V  = 100;
    localparam int NP = H * V;
    localparam int W  = 5;
    localparam int MD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        buf_rvalid = 1'b0;
    logic        disp_ready = 1'b0;
    logic [3:0]  buf_rdata_l = '0;
    logic [3:0]  buf_rdata_r = '0;
    logic [31:0] buf_raddr;
    logic        buf_rready;
    logic [3:0]  disp_out;
    logic        disp_valid;
    logic        sad_done;
`ifdef SAD_COST_OUT_EN
    logic [7:0]  disp_cost;
`endif

    sad_disparity_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .buf_raddr   (buf_raddr),
        .buf_rready  (buf_rready),
        .buf_rvalid  (buf_rvalid),
        .buf_rdata_l (buf_rdata_l),
        .buf_rdata_r (buf_rdata_r),
        .disp_out    (disp_out),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
`ifdef SAD_COST_OUT_EN
        .disp_cost   (disp_cost),
`endif
        .sad_done    (sad_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [3:0] lf [NP];
    logic [3:0] rf [NP];
    int exp_q [$];
    int compares = 0;
    int fails = 0;
    int beats = 0;
    int done_cnt = 0;
    int last_acc_cyc = 0;
    int done_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_out = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        compares++;
        if (obs !== exp_v) begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted disparity.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", disp_valid, 1'b1);
                chk("stall_hold", disp_out, prev_out);
            end
            if (disp_valid && disp_ready) begin
                int e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                chk("disp", int'(disp_out), e);
                beats++;
                last_acc_cyc = cyc;
            end
            if (sad_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = disp_valid && !disp_ready;
            prev_out   = disp_out;
        end
    end

    // mode 0: identical random, 1: right = left shifted 3 px, 2: flat 8
    task automatic load_frame(input int mode);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                case (mode)
                    0: begin
                        lf[y*H+x] = 4'($urandom_range(15));
                        rf[y*H+x] = lf[y*H+x];
                    end
                    1: lf[y*H+x] = 4'($urandom_range(15));
                    default: begin
                        lf[y*H+x] = 4'h8;
                        rf[y*H+x] = 4'h8;
                    end
                endcase
            end
            if (mode == 1) begin
                for (int x = 0; x < H; x++) begin
                    rf[y*H+x] = (x + 3 < H) ? lf[y*H+x+3] : 4'($urandom_range(15));
                end
            end
        end
    endtask

    task automatic push_expected();
        exp_q.delete();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                int best;
                int bs;
                best = 0;
                bs   = 1 << 30;
                for (int d = 0; d < MD; d++) begin
                    if (x >= d + W - 1) begin
                        int s;
                        s = 0;
                        for (int k = 0; k < W; k++) begin
                            int a;
                            int b;
                            a = lf[y*H+x-k];
                            b = rf[y*H+x-k-d];
                            s += (a > b) ? a - b : b - a;
                        end
                        if (s < bs) begin
                            bs   = s;
                            best = d;
                        end
                    end
                end
                exp_q.push_back(best);
            end
        end
    endtask

    task automatic run_frame(input int rv_pct, input int rd_pct, input int abort_at);
        int start_done;
        int budget;
        start_done = done_cnt;
        beats = 0;
        budget = 0;
        push_expected();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        while (done_cnt == start_done && budget < 40000) begin
            buf_rvalid  = ($urandom_range(99) < rv_pct);
            buf_rdata_l = lf[buf_raddr];
            buf_rdata_r = rf[buf_raddr];
            disp_ready  = ($urandom_range(99) < rd_pct);
            if (abort_at >= 0 && int'(buf_raddr) == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_raddr", buf_raddr, 32'd0);
                chk("abort_rready", buf_rready, 1'b0);
                chk("abort_valid", disp_valid, 1'b0);
                chk("abort_disp", disp_out, 4'd0);
                chk("abort_done", sad_done, 1'b0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                buf_rvalid = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                chk("abort_no_done", done_cnt, start_done);
                chk("abort_idle", buf_rready, 1'b0);
                return;
            end
            @(posedge clk); #1;
            budget++;
        end
        chk("done_seen", done_cnt, start_done + 1);
        chk("beats", beats, NP);
        chk("queue_empty", exp_q.size(), 0);
        chk("raddr_end", buf_raddr, 32'(NP - 1));
        chk("done_latency", done_cyc, last_acc_cyc + 1);
        buf_rvalid = 1'b0;
        disp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("single_done", done_cnt, start_done + 1);
        chk("idle_rready", buf_rready, 1'b0);
        chk("idle_valid", disp_valid, 1'b0);
    endtask

    initial begin
        // Reset with frame_start held high: core must stay idle.
        rst_n = 1'b0;
        frame_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_raddr", buf_raddr, 32'd0);
        chk("rst_rready", buf_rready, 1'b0);
        chk("rst_disp", disp_out, 4'd0);
        chk("rst_valid", disp_valid, 1'b0);
        chk("rst_done", sad_done, 1'b0);
        frame_start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stays_idle", buf_rready, 1'b0);

        load_frame(0);
        run_frame(100, 100, -1);

        load_frame(1);
        run_frame(100, 100, -1);

        load_frame(2);
        run_frame(100, 100, -1);

        load_frame(1);
        run_frame(70, 50, -1);

        load_frame(1);
        run_frame(100, 100, 5000);
        run_frame(100, 100, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule

`default_nettype wire
